bitmask_rebuilder: RTL

- Inverse of the priority-encoder stage: consumes a stream of encoded bit positions (pos, nz) from the bit-sparse datapath and rebuilds the original 7-bit bitmask.
- Positions of one group arrive one per beat, and the final beat is flagged `in_last`.
- The rebuilt mask, its popcount and error flags are presented on a registered output with a valid/ready handshake.
- Used on the writeback/checker side to re-expand compressed essential-bit indices.

---
 rtl/bitmask_rebuilder_pkg.sv | 13 +
 rtl/bitmask_rebuilder_p_decoder_3to7.sv | 21 ++
 rtl/bitmask_rebuilder.sv | 101 ++++++++++
 3 files changed

// File: rtl/bitmask_rebuilder_pkg.sv
// Shared widths and types for the bitmask rebuilder, which turns encoded
// bit positions back into a bitmask.
package bitmask_rebuilder_pkg;

  localparam int unsigned MASK_W = 7;
  localparam int unsigned POS_W  = $clog2(MASK_W);
  localparam int unsigned CNT_W  = $clog2(MASK_W + 1);

  typedef logic [MASK_W-1:0] mask_t;
  typedef logic [POS_W-1:0]  pos_t;
  typedef logic [CNT_W-1:0]  cnt_t;

endpackage

// File: rtl/bitmask_rebuilder_p_decoder_3to7.sv
// Position-to-one-hot decoder: the inverse of the encoder mapping, so pos N
// drives bit N. Positions past the mask width raise oor and decode to zero.
module p_decoder_3to7
  import bitmask_rebuilder_pkg::*;
(
  input  pos_t  pos,
  output mask_t oh,
  output logic  oor
);

  localparam pos_t MaxPos = POS_W'(MASK_W - 1);

  always_comb begin
    oh = '0;
    for (int i = 0; i < MASK_W; i++) begin
      oh[i] = (pos == POS_W'(i));
    end
    oor = (pos > MaxPos);
  end

endmodule

// File: rtl/bitmask_rebuilder.sv
// Rebuilds a bitmask from a stream of encoded positions. The result and its
// count and flags are held in a registered valid/ready output stage.
module bitmask_rebuilder
  import bitmask_rebuilder_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  in_valid,
  output logic  in_ready,
  input  pos_t  in_pos,
  input  logic  in_nz,
  input  logic  in_last,
  output logic  out_valid,
  input  logic  out_ready,
  output mask_t out_mask,
  output cnt_t  out_cnt,
  output logic  out_dup,
  output logic  out_err
);

  localparam cnt_t CntMax = CNT_W'(MASK_W);

  mask_t acc_mask_q, acc_mask_d;
  cnt_t  acc_cnt_q, acc_cnt_d;
  logic  acc_dup_q, acc_dup_d;
  logic  acc_err_q, acc_err_d;

  mask_t oh;
  logic  oor;
  logic  fire_in;
  logic  close;

  p_decoder_3to7 u_dec (
    .pos (in_pos),
    .oh  (oh),
    .oor (oor)
  );

  assign in_ready = !(out_valid && !out_ready);
  assign fire_in  = in_valid && in_ready;
  assign close    = fire_in && in_last;

  // Accumulator value including the current beat; only used when fire_in.
  always_comb begin
    acc_mask_d = acc_mask_q;
    acc_cnt_d  = acc_cnt_q;
    acc_dup_d  = acc_dup_q;
    acc_err_d  = acc_err_q;
    if (in_nz) begin
      if (oor) begin
        acc_err_d = 1'b1;
      end else if ((acc_mask_q & oh) != '0) begin
        acc_dup_d = 1'b1;
      end else begin
        acc_mask_d = acc_mask_q | oh;
        if (acc_cnt_q < CntMax) begin
          acc_cnt_d = acc_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_mask_q <= '0;
      acc_cnt_q  <= '0;
      acc_dup_q  <= 1'b0;
      acc_err_q  <= 1'b0;
    end else if (close) begin
      // Clear on close so the next beat opens a fresh group with no bubble.
      acc_mask_q <= '0;
      acc_cnt_q  <= '0;
      acc_dup_q  <= 1'b0;
      acc_err_q  <= 1'b0;
    end else if (fire_in) begin
      acc_mask_q <= acc_mask_d;
      acc_cnt_q  <= acc_cnt_d;
      acc_dup_q  <= acc_dup_d;
      acc_err_q  <= acc_err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_mask  <= '0;
      out_cnt   <= '0;
      out_dup   <= 1'b0;
      out_err   <= 1'b0;
    end else if (close) begin
      out_valid <= 1'b1;
      out_mask  <= acc_mask_d;
      out_cnt   <= acc_cnt_d;
      out_dup   <= acc_dup_d;
      out_err   <= acc_err_d;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
